// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: shares one board LED between N_REQ requesters.
// Requests are latched, granted round-robin, and each grant plays
// (index+1) blinks followed by a quiet gap, then a one-cycle done pulse.
//
// state | meaning
// IDLE  | no pattern running; grant the next pending requester
// ON    | LED lit for ON_CYC cycles of the current blink
// OFF   | LED dark for OFF_CYC cycles after a blink
// GAP   | LED dark for GAP_CYC cycles after the last blink
module led_blink_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ON_CYC  = 4,
  parameter int OFF_CYC = 4,
  parameter int GAP_CYC = 8,
  parameter int TMR_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           key_touch,
  output logic                       led,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [N_REQ-1:0]           pend,
  output logic [N_REQ-1:0]           done
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = ID_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]       state;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] blink_cnt;
  logic [ID_W-1:0]  rr_ptr;

  logic             pick_vld;
  logic [ID_W-1:0]  pick;
  logic [N_REQ-1:0] grant_mask;
  logic             grant;

  assign busy  = (state != S_IDLE);
  assign grant = (state == S_IDLE) && pick_vld;

  // Round-robin search: walk from the farthest slot back toward rr_ptr so the
  // nearest pending requester at or after rr_ptr is the last one written.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (pend[j]) begin
        pick_vld = 1'b1;
        pick     = ID_W'(j);
      end
    end
  end

  // One-hot clear mask for the requester being granted this cycle.
  always_comb begin
    grant_mask = '0;
    if (grant) grant_mask = N_REQ'(1) << pick;
  end

  // Pending latch: a new touch in the grant cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~grant_mask) | key_touch;
  end

  // Blink sequencer: phase timer counts down, terminal count advances state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      led       <= 1'b0;
      timer     <= '0;
      blink_cnt <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
      done      <= '0;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            grant_id  <= pick;
            blink_cnt <= CNT_W'(pick) + CNT_W'(1);
            timer     <= TMR_W'(ON_CYC - 1);
            led       <= 1'b1;
            state     <= S_ON;
          end
        end
        S_ON: begin
          if (timer == '0) begin
            led       <= 1'b0;
            timer     <= TMR_W'(OFF_CYC - 1);
            blink_cnt <= blink_cnt - CNT_W'(1);
            state     <= S_OFF;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_OFF: begin
          if (timer == '0) begin
            if (blink_cnt != '0) begin
              led   <= 1'b1;
              timer <= TMR_W'(ON_CYC - 1);
              state <= S_ON;
            end else begin
              timer <= TMR_W'(GAP_CYC - 1);
              state <= S_GAP;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: begin
          if (timer == '0) begin
            done   <= N_REQ'(1) << grant_id;
            rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            state  <= S_IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
      endcase
    end
  end

endmodule
